// File: rtl/audio_player_core_if.sv
// Sample-memory read port: one-cycle read strobe from the core, data returned
// by the memory on the following cycle.
interface audio_player_core_if #(
    parameter int ADDR_W   = 16,
    parameter int SAMPLE_W = 8
);
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input  mem_data);
    modport slave  (input  mem_rd, input  mem_addr, output mem_data);
endinterface

// File: rtl/audio_player_core.sv
// Sample-rate driven track player: fetches one sample per tick, scales it by
// volume into a PWM DAC, and reports playback progress through the track.
module audio_player_core #(
    parameter int CLK_HZ      = 50000000,
    parameter int SAMPLE_RATE = 8000,
    parameter int SAMPLE_W    = 8,
    parameter int ADDR_W      = 16,
    parameter int TRK_W       = 2,
    parameter int VOL_W       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_btn_play_pause,
    input  logic                           i_btn_next,
    input  logic                           i_btn_prev,
    input  logic                           i_btn_vol_up,
    input  logic                           i_btn_vol_down,
    input  logic [(2**TRK_W)*ADDR_W-1:0]   i_trk_base,
    input  logic [(2**TRK_W)*ADDR_W-1:0]   i_trk_len,
    audio_player_core_if.master            mem,
    output logic                           o_dac_out,
    output logic [TRK_W-1:0]               o_track,
    output logic [VOL_W-1:0]               o_volume,
    output logic [7:0]                     o_progress,
    output logic                           o_song_pause
);
    localparam int NUM_TRACKS = 2**TRK_W;
    localparam int DIV        = CLK_HZ / SAMPLE_RATE;
    localparam int TICK_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int VOL_MAX    = 2**VOL_W - 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2} state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [SAMPLE_W-1:0] r_pwm_cnt;
    logic [TRK_W-1:0]    r_track;
    logic [ADDR_W-1:0]   r_offset;
    logic [VOL_W-1:0]    r_volume;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_cap_pend;
    logic                r_dac;
    logic                r_song_pause;
    logic [7:0]          r_progress;
    logic [ADDR_W-1:0]   r_rem;
    logic [ADDR_W-1:0]   r_dvs;
    logic [6:0]          r_quo;
    logic                r_dsat;
    logic [2:0]          r_dcnt;

    logic [ADDR_W-1:0]   w_base_arr [NUM_TRACKS];
    logic [ADDR_W-1:0]   w_len_arr  [NUM_TRACKS];
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_len;
    logic                w_tick;
    logic                w_pp;
    logic                w_next;
    logic                w_prev;
    logic                w_play_tick;
    logic [VOL_W-1:0]    w_shamt;
    logic [SAMPLE_W-1:0] w_level;

    for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_trk
        assign w_base_arr[gi] = i_trk_base[gi*ADDR_W +: ADDR_W];
        assign w_len_arr[gi]  = i_trk_len[gi*ADDR_W +: ADDR_W];
    end

    assign w_base = w_base_arr[r_track];
    assign w_len  = w_len_arr[r_track];
    assign w_tick = (r_tick_cnt == TICK_W'(DIV - 1));

    // Play/pause outranks next, next outranks prev; any of them eats the tick.
    assign w_pp        = i_btn_play_pause;
    assign w_next      = i_btn_next & ~w_pp;
    assign w_prev      = i_btn_prev & ~w_pp & ~i_btn_next;
    assign w_play_tick = w_tick & (r_state == S_PLAY) & ~(w_pp | w_next | w_prev);

    assign w_shamt = VOL_W'(VOL_MAX) - r_volume;
    assign w_level = (r_state == S_PLAY && r_volume != '0) ? (r_sample >> w_shamt) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_dac      <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_dac      <= (r_pwm_cnt < w_level);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_volume <= VOL_W'(1);
        end else if (i_btn_vol_up && !i_btn_vol_down && r_volume != VOL_W'(VOL_MAX)) begin
            r_volume <= r_volume + 1'b1;
        end else if (i_btn_vol_down && !i_btn_vol_up && r_volume != '0) begin
            r_volume <= r_volume - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_song_pause <= 1'b1;
            r_track      <= '0;
            r_offset     <= '0;
            r_sample     <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_cap_pend   <= 1'b0;
        end else begin
            r_mem_rd   <= 1'b0;
            r_cap_pend <= r_mem_rd;
            if (r_cap_pend) begin
                r_sample <= mem.mem_data;
                r_offset <= r_offset + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pp) begin
                        r_state      <= S_PLAY;
                        r_song_pause <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (w_pp) begin
                        r_state      <= S_PAUSE;
                        r_song_pause <= 1'b1;
                    end else if (w_play_tick) begin
                        if (r_offset < w_len) begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_base + r_offset;
                        end else begin
                            r_track  <= r_track + 1'b1;
                            r_offset <= '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_pp) begin
                        r_state      <= S_PLAY;
                        r_song_pause <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_song_pause <= 1'b1;
                end
            endcase
            // A read in flight for the old track must not bump the fresh offset.
            if (w_next || w_prev) begin
                r_track    <= w_next ? r_track + 1'b1 : r_track - 1'b1;
                r_offset   <= '0;
                r_cap_pend <= 1'b0;
            end
        end
    end

    // Restoring divider for offset*256/len. With offset < len the integer
    // quotient bits are all zero, so the remainder starts as offset and only
    // the 8 fractional bits are iterated; the first one is resolved on the tick.
    logic [ADDR_W-1:0] w_d_rem;
    logic [ADDR_W-1:0] w_d_dvs;
    logic [ADDR_W:0]   w_rem_sh;
    logic              w_q_bit;
    logic [ADDR_W-1:0] w_rem_nx;

    assign w_d_rem  = w_tick ? r_offset : r_rem;
    assign w_d_dvs  = w_tick ? w_len : r_dvs;
    assign w_rem_sh = {w_d_rem, 1'b0};
    assign w_q_bit  = (w_rem_sh >= {1'b0, w_d_dvs});
    assign w_rem_nx = w_q_bit ? ADDR_W'(w_rem_sh - {1'b0, w_d_dvs}) : w_rem_sh[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem      <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_dsat     <= 1'b0;
            r_dcnt     <= '0;
            r_progress <= '0;
        end else if (w_tick) begin
            r_rem  <= w_rem_nx;
            r_dvs  <= w_len;
            r_quo  <= {6'd0, w_q_bit};
            r_dsat <= (r_offset >= w_len);
            r_dcnt <= 3'd7;
        end else if (r_dcnt != '0) begin
            r_rem  <= w_rem_nx;
            r_quo  <= {r_quo[5:0], w_q_bit};
            r_dcnt <= r_dcnt - 1'b1;
            if (r_dcnt == 3'd1) begin
                r_progress <= (r_dvs == '0) ? 8'd0 : (r_dsat ? 8'hFF : {r_quo, w_q_bit});
            end
        end
    end

    assign mem.mem_rd   = r_mem_rd;
    assign mem.mem_addr = r_mem_addr;
    assign o_dac_out    = r_dac;
    assign o_track      = r_track;
    assign o_volume     = r_volume;
    assign o_progress   = r_progress;
    assign o_song_pause = r_song_pause;
endmodule

// File: tb/tb_audio_player_core.sv
// Directed bench for audio_player_core at DIV=8 with an 8-bit address space.
module tb_audio_player_core;
    localparam int AW = 8;
    localparam int SW = 8;
    localparam int TW = 2;
    localparam int VW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            b_pp = 1'b0, b_nx = 1'b0, b_pv = 1'b0, b_up = 1'b0, b_dn = 1'b0;
    logic [4*AW-1:0] trk_base = {8'hF0, 8'h80, 8'h40, 8'h10};
    logic [4*AW-1:0] trk_len  = {8'd20, 8'd20, 8'd20, 8'd4};
    logic [SW-1:0]   mem_val  = 8'hC0;
    logic            dac;
    logic [TW-1:0]   track;
    logic [VW-1:0]   volume;
    logic [7:0]      progress;
    logic            song_pause;
    int              total  = 0;
    int              passed = 0;

    audio_player_core_if #(.ADDR_W(AW), .SAMPLE_W(SW)) m();

    audio_player_core #(
        .CLK_HZ(800), .SAMPLE_RATE(100), .SAMPLE_W(SW),
        .ADDR_W(AW), .TRK_W(TW), .VOL_W(VW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_btn_play_pause(b_pp), .i_btn_next(b_nx), .i_btn_prev(b_pv),
        .i_btn_vol_up(b_up), .i_btn_vol_down(b_dn),
        .i_trk_base(trk_base), .i_trk_len(trk_len),
        .mem(m),
        .o_dac_out(dac), .o_track(track), .o_volume(volume),
        .o_progress(progress), .o_song_pause(song_pause)
    );

    always #5 clk = ~clk;

    // Memory returns the programmed value the cycle after a strobe.
    always @(posedge clk) if (m.mem_rd) m.mem_data <= mem_val;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic pp, input logic nx, input logic pv, input logic up, input logic dn);
        b_pp = pp; b_nx = nx; b_pv = pv; b_up = up; b_dn = dn;
        cyc(1);
        b_pp = 1'b0; b_nx = 1'b0; b_pv = 1'b0; b_up = 1'b0; b_dn = 1'b0;
    endtask

    task automatic wait_rd(input int maxc, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < maxc) begin
            cyc(1);
            n++;
            ok = m.mem_rd;
        end
    endtask

    task automatic count_dac(input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            cyc(1);
            if (dac) hi++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cyc(3);
        total++; if (track !== 2'd0) $display("FAIL reset_track: got %0d want 0", track); else passed++;
        total++; if (volume !== 2'd1) $display("FAIL reset_volume: got %0d want 1", volume); else passed++;
        total++; if (progress !== 8'd0) $display("FAIL reset_progress: got %0d want 0", progress); else passed++;
        total++; if (song_pause !== 1'b1) $display("FAIL reset_song_pause: got %0b want 1", song_pause); else passed++;
        total++; if (m.mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %0b want 0", m.mem_rd); else passed++;
        total++; if (m.mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %0h want 0", m.mem_addr); else passed++;
        total++; if (dac !== 1'b0) $display("FAIL reset_dac: got %0b want 0", dac); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_play_seq;
        int n;
        bit ok;
        press(1, 0, 0, 0, 0);
        total++; if (song_pause !== 1'b0) $display("FAIL play_song_pause: got %0b want 0", song_pause); else passed++;
        for (int k = 0; k < 4; k++) begin
            wait_rd(20, n, ok);
            total++;
            if (!ok || m.mem_addr !== 8'(16 + k))
                $display("FAIL play_addr%0d: got %0h (seen %0b) want %0h", k, m.mem_addr, ok, 16 + k);
            else passed++;
            if (k > 0) begin
                total++; if (n !== 8) $display("FAIL play_spacing%0d: got %0d want 8", k, n); else passed++;
            end
        end
        cyc(8);
        total++; if (m.mem_rd !== 1'b0) $display("FAIL play_end_no_rd: got %0b want 0", m.mem_rd); else passed++;
        total++; if (track !== 2'd1) $display("FAIL play_end_track: got %0d want 1", track); else passed++;
        total++; if (progress !== 8'd192) $display("FAIL play_progress_3of4: got %0d want 192", progress); else passed++;
        cyc(7);
        total++; if (progress !== 8'd255) $display("FAIL play_progress_clamp: got %0d want 255", progress); else passed++;
        cyc(8);
        total++; if (progress !== 8'd0) $display("FAIL play_progress_new_track: got %0d want 0", progress); else passed++;
    endtask

    task automatic test_volume;
        int hi;
        cyc(2);
        count_dac(256, hi);
        total++; if (hi !== 48) $display("FAIL vol1_duty: got %0d want 48", hi); else passed++;
        repeat (3) press(0, 0, 0, 1, 0);
        total++; if (volume !== 2'd3) $display("FAIL vol_up_sat: got %0d want 3", volume); else passed++;
        cyc(2);
        count_dac(256, hi);
        total++; if (hi !== 192) $display("FAIL vol3_duty: got %0d want 192", hi); else passed++;
        press(0, 0, 0, 1, 1);
        total++; if (volume !== 2'd3) $display("FAIL vol_both: got %0d want 3", volume); else passed++;
        repeat (5) press(0, 0, 0, 0, 1);
        total++; if (volume !== 2'd0) $display("FAIL vol_down_sat: got %0d want 0", volume); else passed++;
        cyc(2);
        count_dac(256, hi);
        total++; if (hi !== 0) $display("FAIL vol0_duty: got %0d want 0", hi); else passed++;
        press(0, 0, 0, 1, 0);
    endtask

    task automatic test_pause;
        int n, rds, hi;
        bit ok;
        rst = 1'b0; cyc(2); rst = 1'b1;
        press(1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            wait_rd(20, n, ok);
            total++;
            if (!ok || m.mem_addr !== 8'(16 + k))
                $display("FAIL pause_pre_addr%0d: got %0h (seen %0b) want %0h", k, m.mem_addr, ok, 16 + k);
            else passed++;
        end
        cyc(3);
        press(1, 0, 0, 0, 0);
        total++; if (song_pause !== 1'b1) $display("FAIL pause_song_pause: got %0b want 1", song_pause); else passed++;
        cyc(1);
        rds = 0; hi = 0;
        repeat (40) begin
            cyc(1);
            if (m.mem_rd) rds++;
            if (dac) hi++;
        end
        total++; if (rds !== 0) $display("FAIL pause_reads: got %0d want 0", rds); else passed++;
        total++; if (hi !== 0) $display("FAIL pause_dac: got %0d high want 0", hi); else passed++;
        press(1, 0, 0, 0, 0);
        total++; if (song_pause !== 1'b0) $display("FAIL resume_song_pause: got %0b want 0", song_pause); else passed++;
        wait_rd(20, n, ok);
        total++;
        if (!ok || m.mem_addr !== 8'h12) $display("FAIL resume_addr: got %0h (seen %0b) want 12", m.mem_addr, ok);
        else passed++;
    endtask

    task automatic test_tracks;
        int n;
        bit ok;
        cyc(3);
        press(0, 0, 1, 0, 0);
        total++; if (track !== 2'd3) $display("FAIL prev_wrap: got %0d want 3", track); else passed++;
        wait_rd(20, n, ok);
        total++;
        if (!ok || m.mem_addr !== 8'hF0) $display("FAIL prev_offset0_addr: got %0h (seen %0b) want f0", m.mem_addr, ok);
        else passed++;
        cyc(3);
        press(0, 1, 1, 0, 0);
        total++; if (track !== 2'd0) $display("FAIL next_over_prev: got %0d want 0", track); else passed++;
        press(1, 1, 0, 0, 0);
        total++; if (track !== 2'd0) $display("FAIL pp_over_next_track: got %0d want 0", track); else passed++;
        total++; if (song_pause !== 1'b1) $display("FAIL pp_over_next_state: got %0b want 1", song_pause); else passed++;
        press(1, 0, 0, 0, 0);
        wait_rd(20, n, ok);
        total++;
        if (!ok || m.mem_addr !== 8'h10) $display("FAIL track_change_addr: got %0h (seen %0b) want 10", m.mem_addr, ok);
        else passed++;
    endtask

    task automatic test_progress;
        int n, missing, rds, waited;
        bit ok, skipped;
        trk_len = {8'd20, 8'd20, 8'd0, 8'd200};
        rst = 1'b0; cyc(2); rst = 1'b1;
        press(1, 0, 0, 0, 0);
        missing = 0;
        for (int k = 0; k < 51; k++) begin
            wait_rd(20, n, ok);
            if (!ok) missing++;
        end
        total++; if (missing !== 0) $display("FAIL prog_reads: got %0d missing want 0", missing); else passed++;
        total++; if (progress !== 8'd62) $display("FAIL prog_49of200: got %0d want 62", progress); else passed++;
        cyc(7);
        total++; if (progress !== 8'd64) $display("FAIL prog_50of200: got %0d want 64", progress); else passed++;
        press(0, 1, 0, 0, 0);
        total++; if (track !== 2'd1) $display("FAIL prog_next: got %0d want 1", track); else passed++;
        rds = 0; waited = 0; skipped = 1'b0;
        while (!skipped && waited < 20) begin
            cyc(1);
            waited++;
            if (m.mem_rd) rds++;
            skipped = (track == 2'd2);
        end
        total++; if (!skipped) $display("FAIL len0_skip: got track %0d want 2", track); else passed++;
        total++; if (rds !== 0) $display("FAIL len0_reads: got %0d want 0", rds); else passed++;
        cyc(7);
        total++; if (progress !== 8'd0) $display("FAIL len0_progress: got %0d want 0", progress); else passed++;
    endtask

    task automatic test_reset_mid_read;
        int n, rds, hi;
        bit ok;
        mem_val = 8'hFF;
        press(0, 0, 0, 1, 0);
        wait_rd(20, n, ok);
        total++; if (!ok) $display("FAIL midrst_read_seen: got 0 want 1"); else passed++;
        cyc(1);
        rst = 1'b0;
        #1;
        total++; if (m.mem_rd !== 1'b0) $display("FAIL midrst_mem_rd: got %0b want 0", m.mem_rd); else passed++;
        total++; if (m.mem_addr !== 8'h00) $display("FAIL midrst_mem_addr: got %0h want 0", m.mem_addr); else passed++;
        total++; if (track !== 2'd0) $display("FAIL midrst_track: got %0d want 0", track); else passed++;
        total++; if (volume !== 2'd1) $display("FAIL midrst_volume: got %0d want 1", volume); else passed++;
        total++; if (song_pause !== 1'b1) $display("FAIL midrst_song_pause: got %0b want 1", song_pause); else passed++;
        total++; if (dac !== 1'b0) $display("FAIL midrst_dac: got %0b want 0", dac); else passed++;
        cyc(2);
        rst = 1'b1;
        rds = 0;
        repeat (40) begin
            cyc(1);
            if (m.mem_rd) rds++;
        end
        total++; if (rds !== 0) $display("FAIL midrst_idle_reads: got %0d want 0", rds); else passed++;
        total++; if (song_pause !== 1'b1) $display("FAIL midrst_idle_state: got %0b want 1", song_pause); else passed++;
        press(1, 0, 0, 0, 0);
        hi = 0; n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            cyc(1);
            n++;
            if (dac) hi++;
            ok = m.mem_rd;
        end
        total++; if (hi !== 0) $display("FAIL midrst_no_capture: got %0d dac high want 0", hi); else passed++;
        total++;
        if (!ok || m.mem_addr !== 8'h10) $display("FAIL midrst_first_addr: got %0h (seen %0b) want 10", m.mem_addr, ok);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_play_seq();
        test_volume();
        test_pause();
        test_tracks();
        test_progress();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
